// File: rtl/adder_tree_ctrl.sv
// Feeds an external pipelined adder tree and accumulates per-beat tree sums into per-vector totals.
// Optional saturating overflow handling is compiled in with `define ADDER_TREE_CTRL_OVF_EN.
`timescale 1ns/1ps

module adder_tree_ctrl #(
  parameter int N     = 4,
  parameter int L     = $clog2(N),
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*N-1:0]     in_data,
  input  logic               in_last,
  output logic [8*N-1:0]     tree_ops,
  input  logic [8+L-1:0]     tree_result,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [ACC_W-1:0]   sum_data,
  output logic [15:0]        sum_beats,
  output logic               sum_ovf
);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [L:0]         tag_vld, tag_last;
  logic               tail_vld, tail_last;
  logic               done;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic               acc_ovf, ovf_nxt;
  logic [15:0]        count, count_inc;
  logic [ACC_W:0]     acc_sum;

  assign in_ready  = (state == ACCUM);
  assign sum_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign tail_vld  = tag_vld[L];
  assign tail_last = tag_last[L];

  assign acc_sum   = {1'b0, acc} + {{(ACC_W+1-8-L){1'b0}}, tree_result};
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;

`ifdef ADDER_TREE_CTRL_OVF_EN
  // Once saturated the accumulator stays pinned: any further add carries out again.
  assign acc_nxt = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  assign ovf_nxt = acc_ovf | acc_sum[ACC_W];
`else
  assign acc_nxt = acc_sum[ACC_W-1:0];
  assign ovf_nxt = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next-state is defaulted first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (in_valid && in_last) state_nxt = DRAIN;
      DRAIN:   if (done)                state_nxt = HOLD;
      HOLD:    if (sum_ready)           state_nxt = ACCUM;
      default:                          state_nxt = ACCUM;
    endcase
  end

  // NOTE: every datapath register is reset so an aborted vector leaves no residue behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_ops  <= '0;
      tag_vld   <= '0;
      tag_last  <= '0;
      done      <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      count     <= '0;
      sum_data  <= '0;
      sum_beats <= '0;
      sum_ovf   <= 1'b0;
    end else begin
      tree_ops <= accept ? in_data : '0;
      tag_vld  <= {tag_vld[L-1:0], accept};
      tag_last <= {tag_last[L-1:0], accept && in_last};
      // One-cycle gap between loading the sum and raising sum_valid.
      done     <= tail_vld && tail_last;
      if (tail_vld) begin
        if (!tail_last) begin
          acc     <= acc_nxt;
          acc_ovf <= ovf_nxt;
          count   <= count_inc;
        end else begin
          sum_data  <= acc_nxt;
          sum_beats <= count_inc;
          sum_ovf   <= ovf_nxt;
          acc       <= '0;
          acc_ovf   <= 1'b0;
          count     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Directed bench for adder_tree_ctrl with a behavioural L-stage adder tree behind tree_ops.
`timescale 1ns/1ps

module tb_adder_tree_ctrl;

  localparam int N     = 4;
  localparam int L     = 2;
  localparam int ACC_W = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [8*N-1:0]     in_data;
  logic               in_last;
  logic [8*N-1:0]     tree_ops;
  logic [8+L-1:0]     tree_result;
  logic               sum_valid;
  logic               sum_ready;
  logic [ACC_W-1:0]   sum_data;
  logic [15:0]        sum_beats;
  logic               sum_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  adder_tree_ctrl #(.N(N), .L(L), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .tree_ops   (tree_ops),
    .tree_result(tree_result),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .sum_beats  (sum_beats),
    .sum_ovf    (sum_ovf)
  );

  always #5 clk = ~clk;

  // Adder tree model: full byte sum registered, then delayed to L register stages in total.
  function automatic logic [8+L-1:0] byte_sum(input logic [8*N-1:0] d);
    logic [8+L-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + {{L{1'b0}}, d[8*i +: 8]};
    return s;
  endfunction

  logic [8+L-1:0] tree_pipe [L];
  always_ff @(posedge clk) begin
    tree_pipe[0] <= byte_sum(tree_ops);
    for (int i = 1; i < L; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_result = tree_pipe[L-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  // Counts edges until sum_valid rises; an expired budget fails the sum_valid check.
  task automatic wait_sum(input string tag, output int lat);
    lat = 0;
    while (!sum_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " sum_valid"}, 32'(sum_valid), 32'd1);
  endtask

  logic [ACC_W-1:0] exp_ovf_data;
  logic             exp_ovf_flag;

  initial begin
    int  lat;
    bit  stable;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    sum_ready = 1'b1;
    repeat (3) step();

    check("rst sum_valid", 32'(sum_valid), 32'd0);
    check("rst sum_data",  32'(sum_data),  32'd0);
    check("rst sum_beats", 32'(sum_beats), 32'd0);
    check("rst sum_ovf",   32'(sum_ovf),   32'd0);
    check("rst tree_ops",  tree_ops,       32'd0);
    rst = 1'b0;
    step();
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Two-beat vector, latency from last accept to sum_valid.
    send(32'h04030201, 1'b0);
    send(32'h08070605, 1'b1);
    check("drain in_ready", 32'(in_ready), 32'd0);
    wait_sum("v2", lat);
    check("v2 latency",   32'(lat),       32'd4);
    check("v2 sum_data",  32'(sum_data),  32'd36);
    check("v2 sum_beats", 32'(sum_beats), 32'd2);
    step();
    check("v2 release sum_valid", 32'(sum_valid), 32'd0);
    check("v2 release in_ready",  32'(in_ready),  32'd1);

    // Single-beat vector at byte maximum.
    send(32'hFFFFFFFF, 1'b1);
    wait_sum("v1", lat);
    check("v1 sum_data",  32'(sum_data),  32'd1020);
    check("v1 sum_beats", 32'(sum_beats), 32'd1);
    check("v1 sum_ovf",   32'(sum_ovf),   32'd0);
    step();

    // Backpressure in HOLD; garbage offered meanwhile must be ignored.
    sum_ready = 1'b0;
    send(32'h281E140A, 1'b1);
    wait_sum("bp", lat);
    in_valid = 1'b1;
    in_data  = 32'hAAAAAAAA;
    in_last  = 1'b1;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(sum_valid === 1'b1 && sum_data === 12'd100 && in_ready === 1'b0 && sum_beats === 16'd1))
        stable = 1'b0;
    end
    check("bp hold stable", 32'(stable), 32'd1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    sum_ready = 1'b1;
    step();
    check("bp release in_ready", 32'(in_ready), 32'd1);
    send(32'h01010101, 1'b1);
    wait_sum("bp next", lat);
    check("bp next sum_data",  32'(sum_data),  32'd4);
    check("bp next sum_beats", 32'(sum_beats), 32'd1);
    step();

    // Accumulator overflow: five beats of 1020 into a 12-bit accumulator.
`ifdef ADDER_TREE_CTRL_OVF_EN
    exp_ovf_data = 12'd4095;
    exp_ovf_flag = 1'b1;
`else
    exp_ovf_data = 12'd1004;
    exp_ovf_flag = 1'b0;
`endif
    for (int i = 0; i < 5; i++) send(32'hFFFFFFFF, i == 4);
    wait_sum("ovf", lat);
    check("ovf sum_data",  32'(sum_data),  32'(exp_ovf_data));
    check("ovf sum_ovf",   32'(sum_ovf),   32'(exp_ovf_flag));
    check("ovf sum_beats", 32'(sum_beats), 32'd5);
    step();
    check("ovf clears sum_valid", 32'(sum_valid), 32'd0);

    // in_valid bubbles insert no beats.
    send(32'h01010101, 1'b0);
    step();
    send(32'h01010101, 1'b0);
    step();
    send(32'h01010101, 1'b1);
    wait_sum("bubble", lat);
    check("bubble sum_data",  32'(sum_data),  32'd12);
    check("bubble sum_beats", 32'(sum_beats), 32'd3);
    step();

    // Asynchronous reset while draining a three-beat vector.
    send(32'h02020202, 1'b0);
    send(32'h02020202, 1'b0);
    send(32'h02020202, 1'b1);
    check("pre-rst drain in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async rst sum_data",  32'(sum_data),  32'd0);
    check("async rst sum_beats", 32'(sum_beats), 32'd0);
    check("async rst tree_ops",  tree_ops,       32'd0);
    check("async rst in_ready",  32'(in_ready),  32'd1);
    step();
    rst = 1'b0;
    step();
    check("rst release in_ready",  32'(in_ready),  32'd1);
    check("rst release sum_valid", 32'(sum_valid), 32'd0);
    send(32'h01010101, 1'b1);
    wait_sum("after rst", lat);
    check("after rst sum_data",  32'(sum_data),  32'd4);
    check("after rst sum_beats", 32'(sum_beats), 32'd1);
    check("after rst sum_ovf",   32'(sum_ovf),   32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
